// File: rtl/payload_class_engine.sv
// Runtime-programmable literal/character-class matcher using a shift-and state vector.
// Optional per-position case folding is built when PAYLOAD_CLASS_NOCASE_EN is defined.
module payload_class_engine #(
  parameter int unsigned MAX_LEN  = 16,
  parameter bit          ANCHORED = 1'b0,
  parameter int unsigned OFF_W    = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       sod,
  input  logic                       en,
  input  logic [7:0]                 data_in,
  input  logic                       cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0] cfg_addr,
  input  logic [7:0]                 cfg_lo,
  input  logic [7:0]                 cfg_hi,
  input  logic                       cfg_nocase,
  input  logic                       cfg_len_we,
  input  logic [$clog2(MAX_LEN):0]   cfg_len,
  output logic                       match,
  output logic                       match_pulse,
  output logic [OFF_W-1:0]           first_off,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  logic [7:0]         cls_lo [MAX_LEN];
  logic [7:0]         cls_hi [MAX_LEN];
  logic [LW-1:0]      len;
  logic [MAX_LEN-1:0] state;
  logic [OFF_W-1:0]   off;

  logic [7:0]         cmp_byte_c [MAX_LEN];
  logic [MAX_LEN-1:0] class_hit_c;
  logic [MAX_LEN-1:0] len_mask_c;
  logic [MAX_LEN-1:0] state_next_c;
  logic               start_c;
  logic               hit_c;

`ifdef PAYLOAD_CLASS_NOCASE_EN
  logic [MAX_LEN-1:0] nocase;
`else
  logic unused_nocase;
  assign unused_nocase = cfg_nocase;
`endif

  // Class table and length survive sod; only explicit writes change them.
  always_ff @(posedge clk) begin
    if (cfg_we && (32'(cfg_addr) < MAX_LEN)) begin
      cls_lo[cfg_addr] <= cfg_lo;
      cls_hi[cfg_addr] <= cfg_hi;
`ifdef PAYLOAD_CLASS_NOCASE_EN
      nocase[cfg_addr] <= cfg_nocase;
`endif
    end
    if (cfg_len_we) begin
      len <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    end
  end

  // Per-position class test, shift-and advance and hit detection at position len-1.
  always_comb begin
    class_hit_c  = '0;
    len_mask_c   = '0;
    state_next_c = '0;
    hit_c        = 1'b0;
    start_c      = ANCHORED ? (off == '0) : 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      cmp_byte_c[i] = data_in;
`ifdef PAYLOAD_CLASS_NOCASE_EN
      if (nocase[i] && (data_in >= 8'h41) && (data_in <= 8'h5A)) begin
        cmp_byte_c[i] = data_in | 8'h20;
      end
`endif
      class_hit_c[i] = (cmp_byte_c[i] >= cls_lo[i]) && (cmp_byte_c[i] <= cls_hi[i]);
      len_mask_c[i]  = LW'(i) < len;
    end
    state_next_c[0] = class_hit_c[0] & start_c & len_mask_c[0];
    for (int i = 1; i < MAX_LEN; i++) begin
      state_next_c[i] = state[i-1] & class_hit_c[i] & len_mask_c[i];
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i + 1) == len) begin
        hit_c = state_next_c[i];
      end
    end
  end

  // Match state, offset counter and result registers; all advance only on accepted bytes.
  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      state       <= '0;
      off         <= '0;
      match       <= 1'b0;
      match_pulse <= 1'b0;
      first_off   <= '0;
      match_cnt   <= '0;
    end else begin
      match_pulse <= 1'b0;
      if (en) begin
        state       <= state_next_c;
        match_pulse <= hit_c;
        if (off != '1) begin
          off <= off + OFF_W'(1);
        end
        if (hit_c) begin
          match <= 1'b1;
          if (!match) begin
            first_off <= off;
          end
          if (match_cnt != '1) begin
            match_cnt <= match_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_payload_class_engine.sv
// Self-checking bench: three engine variants share stimulus and are checked against a
// sliding-window model of the class sequence.
module tb_payload_class_engine;

  localparam int unsigned MAXL = 16;
  localparam bit ANC  [3] = '{1'b0, 1'b1, 1'b0};
  localparam int OMAX [3] = '{65535, 65535, 7};
  localparam int CMAX [3] = '{255, 255, 3};

  logic       clk = 1'b0;
  logic       sod, en, cfg_we, cfg_nocase, cfg_len_we;
  logic [7:0] data_in, cfg_lo, cfg_hi;
  logic [3:0] cfg_addr;
  logic [4:0] cfg_len;

  logic        m0, p0, m1, p1, m2, p2;
  logic [15:0] f0, f1;
  logic [2:0]  f2;
  logic [7:0]  c0, c1;
  logic [1:0]  c2;

  always #5 clk = ~clk;

  payload_class_engine #(.MAX_LEN(16), .ANCHORED(1'b0), .OFF_W(16), .CNT_W(8)) dut0 (
    .clk(clk), .sod(sod), .en(en), .data_in(data_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_nocase(cfg_nocase), .cfg_len_we(cfg_len_we),
    .cfg_len(cfg_len), .match(m0), .match_pulse(p0), .first_off(f0), .match_cnt(c0));

  payload_class_engine #(.MAX_LEN(16), .ANCHORED(1'b1), .OFF_W(16), .CNT_W(8)) dut1 (
    .clk(clk), .sod(sod), .en(en), .data_in(data_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_nocase(cfg_nocase), .cfg_len_we(cfg_len_we),
    .cfg_len(cfg_len), .match(m1), .match_pulse(p1), .first_off(f1), .match_cnt(c1));

  payload_class_engine #(.MAX_LEN(16), .ANCHORED(1'b0), .OFF_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .sod(sod), .en(en), .data_in(data_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_nocase(cfg_nocase), .cfg_len_we(cfg_len_we),
    .cfg_len(cfg_len), .match(m2), .match_pulse(p2), .first_off(f2), .match_cnt(c2));

  logic        o_match [3];
  logic        o_pulse [3];
  logic [15:0] o_first [3];
  logic [7:0]  o_cnt   [3];
  assign o_match[0] = m0;  assign o_pulse[0] = p0;  assign o_first[0] = f0;  assign o_cnt[0] = c0;
  assign o_match[1] = m1;  assign o_pulse[1] = p1;  assign o_first[1] = f1;  assign o_cnt[1] = c1;
  assign o_match[2] = m2;  assign o_pulse[2] = p2;  assign o_first[2] = {13'd0, f2};
  assign o_cnt[2]   = {6'd0, c2};

  // Reference model: the pattern hits when the last len accepted bytes satisfy the classes.
  logic [7:0] m_lo [MAXL];
  logic [7:0] m_hi [MAXL];
`ifdef PAYLOAD_CLASS_NOCASE_EN
  bit         m_nc [MAXL];
`endif
  int         m_len;
  logic [7:0] hist [$];
  int         nacc;
  bit         e_match [3];
  bit         e_pulse [3];
  int         e_first [3];
  int         e_cnt   [3];
  int         checks = 0;
  int         errors = 0;

  function automatic bit cls_ok(input int j, input logic [7:0] b);
    logic [7:0] x;
    x = b;
`ifdef PAYLOAD_CLASS_NOCASE_EN
    if (m_nc[j] && b >= 8'h41 && b <= 8'h5A) x = b + 8'd32;
`endif
    return (x >= m_lo[j]) && (x <= m_hi[j]);
  endfunction

  task automatic model_reset();
    hist.delete();
    nacc = 0;
    for (int k = 0; k < 3; k++) begin
      e_match[k] = 0; e_pulse[k] = 0; e_first[k] = 0; e_cnt[k] = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n;
    bit win, hit;
    hist.push_back(b);
    n = hist.size();
    win = 0;
    if (m_len > 0 && n >= m_len) begin
      win = 1;
      for (int j = 0; j < m_len; j++) if (!cls_ok(j, hist[n - m_len + j])) win = 0;
    end
    for (int k = 0; k < 3; k++) begin
      hit = win && (!ANC[k] || n == m_len);
      e_pulse[k] = hit;
      if (hit) begin
        if (!e_match[k]) e_first[k] = (nacc < OMAX[k]) ? nacc : OMAX[k];
        e_match[k] = 1;
        if (e_cnt[k] < CMAX[k]) e_cnt[k] = e_cnt[k] + 1;
      end
    end
    nacc = nacc + 1;
  endtask

  // One clock cycle from a falling edge to the next; config takes effect after the byte.
  task automatic step(input bit v, input logic [7:0] b);
    en = v;
    data_in = b;
    @(posedge clk);
    if (v) model_byte(b);
    else for (int k = 0; k < 3; k++) e_pulse[k] = 0;
    if (cfg_we && int'(cfg_addr) < MAXL) begin
      m_lo[cfg_addr] = cfg_lo;
      m_hi[cfg_addr] = cfg_hi;
`ifdef PAYLOAD_CLASS_NOCASE_EN
      m_nc[cfg_addr] = cfg_nocase;
`endif
    end
    if (cfg_len_we) m_len = (int'(cfg_len) > MAXL) ? MAXL : int'(cfg_len);
    @(negedge clk);
    en = 0; cfg_we = 0; cfg_len_we = 0;
  endtask

  task automatic set_class(input int a, input logic [7:0] lo, input logic [7:0] hi, input bit nc);
    cfg_we = 1; cfg_addr = 4'(a); cfg_lo = lo; cfg_hi = hi; cfg_nocase = nc;
    step(0, 8'h00);
  endtask

  task automatic set_len(input int l);
    cfg_len_we = 1; cfg_len = 5'(l);
    step(0, 8'h00);
  endtask

  task automatic program_str(input string s, input bit nc);
    for (int i = 0; i < s.len(); i++) set_class(i, s[i], s[i], nc);
    set_len(s.len());
  endtask

  task automatic do_sod();
    sod = 1;
    model_reset();
    @(negedge clk);
    sod = 0;
  endtask

  task automatic test_reset();
    sod = 1; en = 0; data_in = 0; cfg_we = 0; cfg_len_we = 0;
    cfg_addr = 0; cfg_lo = 0; cfg_hi = 0; cfg_nocase = 0; cfg_len = 0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_match[k] !== 1'b0 || o_pulse[k] !== 1'b0 || o_first[k] !== 16'd0 || o_cnt[k] !== 8'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got match=%0b pulse=%0b first=%0d cnt=%0d, expected all 0",
                 k, o_match[k], o_pulse[k], o_first[k], o_cnt[k]);
      end
    end
    sod = 0;
    for (int i = 0; i < MAXL; i++) set_class(i, 8'hFF, 8'h00, 0);
    set_len(0);
  endtask

  task automatic test_literal();
    string s;
    program_str(".asp?", 0);
    do_sod();
    s = "x.asp?y";
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_match[k] !== e_match[k] || o_pulse[k] !== e_pulse[k] || o_first[k] !== 16'(e_first[k]) || o_cnt[k] !== 8'(e_cnt[k])) begin
          errors++;
          $display("FAIL literal dut%0d byte%0d: got m=%0b p=%0b f=%0d c=%0d, expected m=%0b p=%0b f=%0d c=%0d",
                   k, i, o_match[k], o_pulse[k], o_first[k], o_cnt[k], e_match[k], e_pulse[k], e_first[k], e_cnt[k]);
        end
      end
      if (i == 5) begin
        checks++;
        if (p0 !== 1'b1 || f0 !== 16'd5 || c0 !== 8'd1) begin
          errors++;
          $display("FAIL literal_hit: got p=%0b f=%0d c=%0d, expected p=1 f=5 c=1", p0, f0, c0);
        end
      end
    end
    checks++;
    if (m0 !== 1'b1 || p0 !== 1'b0) begin
      errors++;
      $display("FAIL literal_sticky: got m=%0b p=%0b, expected m=1 p=0", m0, p0);
    end
    do_sod();
    s = ".asp.asp?";
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_match[k] !== e_match[k] || o_pulse[k] !== e_pulse[k] || o_first[k] !== 16'(e_first[k]) || o_cnt[k] !== 8'(e_cnt[k])) begin
          errors++;
          $display("FAIL partial dut%0d byte%0d: got m=%0b p=%0b f=%0d c=%0d, expected m=%0b p=%0b f=%0d c=%0d",
                   k, i, o_match[k], o_pulse[k], o_first[k], o_cnt[k], e_match[k], e_pulse[k], e_first[k], e_cnt[k]);
        end
      end
    end
    checks++;
    if (f0 !== 16'd8 || c0 !== 8'd1 || f2 !== 3'd7) begin
      errors++;
      $display("FAIL partial_final: got f0=%0d c0=%0d f2=%0d, expected f0=8 c0=1 f2=7", f0, c0, f2);
    end
  endtask

  task automatic test_anchored();
    string s;
    program_str("ab", 0);
    for (int r = 0; r < 2; r++) begin
      do_sod();
      s = (r == 0) ? "ab" : "xab";
      for (int i = 0; i < s.len(); i++) begin
        step(1, s[i]);
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (o_match[k] !== e_match[k] || o_pulse[k] !== e_pulse[k] || o_first[k] !== 16'(e_first[k]) || o_cnt[k] !== 8'(e_cnt[k])) begin
            errors++;
            $display("FAIL anchored dut%0d run%0d byte%0d: got m=%0b p=%0b f=%0d c=%0d, expected m=%0b p=%0b f=%0d c=%0d",
                     k, r, i, o_match[k], o_pulse[k], o_first[k], o_cnt[k], e_match[k], e_pulse[k], e_first[k], e_cnt[k]);
          end
        end
      end
      checks++;
      if (r == 0 && (m1 !== 1'b1 || f1 !== 16'd1)) begin
        errors++;
        $display("FAIL anchored_ab: got m=%0b f=%0d, expected m=1 f=1", m1, f1);
      end else if (r == 1 && (m1 !== 1'b0 || m0 !== 1'b1)) begin
        errors++;
        $display("FAIL anchored_xab: got m1=%0b m0=%0b, expected m1=0 m0=1", m1, m0);
      end
    end
  endtask

  task automatic test_overlap();
    program_str("aa", 0);
    do_sod();
    for (int i = 0; i < 6; i++) begin
      step(1, "a");
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_match[k] !== e_match[k] || o_pulse[k] !== e_pulse[k] || o_first[k] !== 16'(e_first[k]) || o_cnt[k] !== 8'(e_cnt[k])) begin
          errors++;
          $display("FAIL overlap dut%0d byte%0d: got m=%0b p=%0b f=%0d c=%0d, expected m=%0b p=%0b f=%0d c=%0d",
                   k, i, o_match[k], o_pulse[k], o_first[k], o_cnt[k], e_match[k], e_pulse[k], e_first[k], e_cnt[k]);
        end
      end
      if (i == 3) begin
        checks++;
        if (c0 !== 8'd3) begin
          errors++;
          $display("FAIL overlap_cnt: got %0d, expected 3", c0);
        end
      end
    end
    checks++;
    if (c0 !== 8'd5 || c2 !== 2'd3) begin
      errors++;
      $display("FAIL cnt_saturate: got c0=%0d c2=%0d, expected c0=5 c2=3", c0, c2);
    end
  endtask

  task automatic test_sod_mid();
    string s;
    program_str(".asp?", 0);
    do_sod();
    s = "x.asp?";
    for (int i = 0; i < s.len(); i++) step(1, s[i]);
    sod = 1;
    #1;
    checks++;
    if ({m0, p0, f0, c0} !== 26'd0 || {m2, p2, f2, c2} !== 7'd0) begin
      errors++;
      $display("FAIL async_sod: got m0=%0b p0=%0b f0=%0d c0=%0d m2=%0b, expected all 0", m0, p0, f0, c0, m2);
    end
    model_reset();
    @(negedge clk);
    sod = 0;
    s = "x.as";
    for (int i = 0; i < s.len(); i++) step(1, s[i]);
    do_sod();
    s = "p?";
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_match[k] !== e_match[k] || o_pulse[k] !== e_pulse[k] || o_first[k] !== 16'(e_first[k]) || o_cnt[k] !== 8'(e_cnt[k])) begin
          errors++;
          $display("FAIL sod_mid dut%0d byte%0d: got m=%0b p=%0b f=%0d c=%0d, expected m=%0b p=%0b f=%0d c=%0d",
                   k, i, o_match[k], o_pulse[k], o_first[k], o_cnt[k], e_match[k], e_pulse[k], e_first[k], e_cnt[k]);
        end
      end
    end
    set_len(0);
    do_sod();
    s = ".asp?x.asp?";
    for (int i = 0; i < 30; i++) step(1, s[$urandom_range(0, 10)]);
    checks++;
    if (m0 !== 1'b0 || c0 !== 8'd0 || m1 !== 1'b0) begin
      errors++;
      $display("FAIL len_zero: got m0=%0b c0=%0d m1=%0b, expected 0 0 0", m0, c0, m1);
    end
  endtask

  task automatic test_cfg_timing();
    program_str("ab", 0);
    do_sod();
    step(1, "a");
    cfg_len_we = 1; cfg_len = 5'd1;
    step(1, "b");
    checks++;
    if (p0 !== 1'b1 || c0 !== 8'd1) begin
      errors++;
      $display("FAIL len_write_same_cycle: got p=%0b c=%0d, expected p=1 c=1", p0, c0);
    end
    cfg_we = 1; cfg_addr = 4'd0; cfg_lo = "z"; cfg_hi = "z"; cfg_nocase = 0;
    step(1, "a");
    step(1, "a");
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_match[k] !== e_match[k] || o_pulse[k] !== e_pulse[k] || o_first[k] !== 16'(e_first[k]) || o_cnt[k] !== 8'(e_cnt[k])) begin
        errors++;
        $display("FAIL cfg_timing dut%0d: got m=%0b p=%0b f=%0d c=%0d, expected m=%0b p=%0b f=%0d c=%0d",
                 k, o_match[k], o_pulse[k], o_first[k], o_cnt[k], e_match[k], e_pulse[k], e_first[k], e_cnt[k]);
      end
    end
    for (int i = 0; i < MAXL; i++) set_class(i, "q", "q", 0);
    set_len(20);
    do_sod();
    for (int i = 0; i < 17; i++) begin
      step(1, "q");
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_match[k] !== e_match[k] || o_pulse[k] !== e_pulse[k] || o_first[k] !== 16'(e_first[k]) || o_cnt[k] !== 8'(e_cnt[k])) begin
          errors++;
          $display("FAIL len_clamp dut%0d byte%0d: got m=%0b p=%0b f=%0d c=%0d, expected m=%0b p=%0b f=%0d c=%0d",
                   k, i, o_match[k], o_pulse[k], o_first[k], o_cnt[k], e_match[k], e_pulse[k], e_first[k], e_cnt[k]);
        end
      end
    end
    checks++;
    if (c0 !== 8'd2 || f0 !== 16'd15) begin
      errors++;
      $display("FAIL len_clamp_final: got c=%0d f=%0d, expected c=2 f=15", c0, f0);
    end
  endtask

  task automatic test_nocase();
    string s;
    bit exp_hit;
`ifdef PAYLOAD_CLASS_NOCASE_EN
    exp_hit = 1;
`else
    exp_hit = 0;
`endif
    program_str("asp", 1);
    do_sod();
    s = "ASP";
    for (int i = 0; i < s.len(); i++) step(1, s[i]);
    checks++;
    if (m0 !== exp_hit || m1 !== exp_hit) begin
      errors++;
      $display("FAIL nocase: got m0=%0b m1=%0b, expected %0b", m0, m1, exp_hit);
    end
  endtask

  task automatic test_random();
    string alpha;
    int len;
    alpha = "abcdABCDz";
    for (int seg = 0; seg < 10; seg++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 18) : $urandom_range(1, 3);
      for (int i = 0; i < MAXL; i++)
        set_class(i, 8'($urandom_range(97, 100)), 8'($urandom_range(96, 100)), $urandom_range(0, 1) == 1);
      set_len(len);
      do_sod();
      for (int t = 0; t < 50; t++) begin
        if ($urandom_range(0, 39) == 0) do_sod();
        step($urandom_range(0, 3) != 0, alpha[$urandom_range(0, 8)]);
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (o_match[k] !== e_match[k] || o_pulse[k] !== e_pulse[k] || o_first[k] !== 16'(e_first[k]) || o_cnt[k] !== 8'(e_cnt[k])) begin
            errors++;
            $display("FAIL random dut%0d seg%0d t%0d: got m=%0b p=%0b f=%0d c=%0d, expected m=%0b p=%0b f=%0d c=%0d",
                     k, seg, t, o_match[k], o_pulse[k], o_first[k], o_cnt[k], e_match[k], e_pulse[k], e_first[k], e_cnt[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_literal();
    test_anchored();
    test_overlap();
    test_sod_mid();
    test_cfg_timing();
    test_nocase();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/payload_class_engine.md
Name: payload_class_engine

Overview:
- Parametrised, runtime-programmable successor to the fixed per-rule payload engines.
- Matches one literal/character-class sequence of up to MAX_LEN positions against the payload byte stream, using a bit-parallel shift-and state vector.
- Instantiated per rule slot in the payload engine array.
- Adds byte-offset capture, a match counter and optional anchoring.

Parameters:
- MAX_LEN, 16, number of pattern positions (state-vector width); legal range 2..64.
- ANCHORED, 0, 1 = a match may only begin at payload byte offset 0; 0 = a match may begin at any offset.
- OFF_W, 16, width of the byte-offset counter and captured offset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock.
- sod  in  1  asynchronous active-high reset; start of data; clears all match state.
- en  in  1  data valid; data_in is consumed on a rising clk edge when en=1.
- data_in  in  8  payload byte.
- cfg_we  in  1  write strobe for the position class table.
- cfg_addr  in  clog2(MAX_LEN)  position index being written.
- cfg_lo  in  8  inclusive lower bound of the class.
- cfg_hi  in  8  inclusive upper bound of the class.
- cfg_nocase  in  1  case-fold flag for the position.
- cfg_len_we  in  1  write strobe for the pattern length.
- cfg_len  in  clog2(MAX_LEN)+1  active pattern length, 0..MAX_LEN.
- match  out  1  sticky: at least one match since sod.
- match_pulse  out  1  one-cycle pulse per completed match.
- first_off  out  OFF_W  offset of the byte that completed the first match.
- match_cnt  out  CNT_W  number of matches since sod, saturating.

Behaviour:
- Reset (sod=1, asynchronous): state vector, byte offset, match, match_pulse, first_off and match_cnt all go to 0.
- The class table and length register are not cleared by sod. They hold their last written values; power-up contents are don't-care until written.
- Class test: position i matches byte b when lo_i <= b <= hi_i, unsigned compare. If lo_i > hi_i the position never matches.
- Update rule, applied only on edges with en=1, where M[i] is the class test of position i on data_in:
  - S'[0] = M[0] AND start. start = 1 when ANCHORED=0; when ANCHORED=1, start = (off == 0).
  - S'[i] = S[i-1] AND M[i], for i >= 1.
  - Bits with i >= len are forced to 0.
- Hit = S'[len-1] when len >= 1. When len = 0 there is never a hit.
- Latency: a hit produced by the byte accepted at edge k is reflected in every output register at edge k:
  - match_pulse = 1 for exactly that cycle;
  - match is set and stays set;
  - match_cnt increments, saturating at all-ones;
  - first_off is loaded with the current offset, only if match was 0 before that edge.
- Overlapping matches each count separately (e.g. pattern "aa" on "aaa" gives 2).
- Offset counter: the offset of a byte is the number of bytes accepted since sod before it. The first byte after sod has offset 0. The counter increments per accepted byte and saturates at all-ones. Once saturated, ANCHORED starts are impossible.
- en = 0: nothing changes except match_pulse, which returns to 0.
- Config writes:
  - take effect at the edge after the write, so a write and a byte accepted in the same cycle evaluate with the old config;
  - cfg_addr >= MAX_LEN is ignored;
  - cfg_len > MAX_LEN is clamped to MAX_LEN;
  - changing len mid-stream is legal; state bits beyond the new len are cleared on the next accepted byte.
- sod asserted mid-match discards all partial state. The next byte is treated as offset 0.

Optional Feature:
- Macro PAYLOAD_CLASS_NOCASE_EN.
- Defined: a per-position nocase bit is stored. When it is set, bytes 0x41..0x5A are folded to 0x61..0x7A before the class test for that position. Classes for such positions are programmed in lower case.
- Not defined: cfg_nocase is ignored, no storage is built, and all compares are exact.

Test Plan:
- Program ".asp?" as len 5 (0x2E, a, s, p, 0x3F, each lo=hi), ANCHORED=0, stream "x.asp?y" with en=1 -> match_pulse in the cycle after byte 5 is accepted; first_off=5; match_cnt=1; match stays 1 through the 'y' byte.
- Same pattern on stream ".asp.asp?" -> a single hit with first_off=8; no hit from the first partial ".asp".
- ANCHORED=1, pattern "ab": stream "ab" -> hit, first_off=1. Stream "xab" after sod -> no hit, match=0.
- Pattern "aa" on "aaaa" -> three pulses, match_cnt=3. With CNT_W=2 and 5 matches -> match_cnt holds at 3.
- Assert sod after "x.as", then stream "p?" -> no hit, all outputs 0. Also len=0 on any stream -> no hit ever.
- With PAYLOAD_CLASS_NOCASE_EN defined and nocase=1 on every position of "asp": stream "ASP" -> hit. Without the macro -> no hit.
